// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if -- bundle of every signal between the multiply/divide
// controller and its environment.
//
//   request side : req_valid, req_op[2:0], req_a[31:0], req_b[31:0] -> ctrl
//                  req_ready                                       <- ctrl
//   control      : flush -> ctrl ; busy, hi[31:0], lo[31:0] <- ctrl
//   divider      : div_valid, div_sig, div_a, div_b <- ctrl ;
//                  div_done, div_c[63:0] -> ctrl   (c = {remainder, quotient})
//   multiplier   : mul_valid, mul_sig, mul_a, mul_b <- ctrl ;
//                  mul_done, mul_c[63:0] -> ctrl   (c = {high, low})
//
// The controller connects through modport "slave"; the environment (the
// pipeline plus both arithmetic units) uses modport "master".
interface mdu_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;

    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        div_valid;
    logic        div_sig;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [63:0] div_c;

    logic        mul_valid;
    logic        mul_sig;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [63:0] mul_c;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        input  div_done, div_c, mul_done, mul_c,
        output req_ready, busy, hi, lo,
        output div_valid, div_sig, div_a, div_b,
        output mul_valid, mul_sig, mul_a, mul_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        output div_done, div_c, mul_done, mul_c,
        input  req_ready, busy, hi, lo,
        input  div_valid, div_sig, div_a, div_b,
        input  mul_valid, mul_sig, mul_a, mul_b
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- sequencer for a MIPS-style HI/LO multiply/divide unit.
//
// Ports:
//   clk     in   clock
//   resetn  in   synchronous, active-low reset
//   bus     mdu_ctrl_if.slave -- request handshake, flush, busy, HI/LO
//           outputs, and start/done handshakes to an external divider and
//           multiplier (see mdu_ctrl_if for the member list).
//
// One operation is in flight at a time. MTHI/MTLO complete in IDLE in the
// accepting cycle. MULT/MULTU/DIV/DIVU latch their operands, pulse the unit's
// valid for one cycle, wait for its done, and capture {hi, lo} from its
// result. A divide by zero is accepted but dropped. A flush while running
// abandons the result; the unit is still allowed to finish (DRAIN) so it is
// idle before the next start.
module mdu_ctrl (
    input  logic      clk,
    input  logic      resetn,
    mdu_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        DIV_RUN,
        DIV_CAP,
        MUL_RUN,
        MUL_CAP,
        DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] op_a_reg, op_a_next;
    logic [31:0] op_b_reg, op_b_next;
    logic        op_sig_reg, op_sig_next;
    // Remembers which unit was started so DRAIN waits on the right done.
    logic        unit_mul_reg, unit_mul_next;
    // High only in the first cycle of a RUN state: drives the start pulse
    // and masks the stale done that an idle unit reports.
    logic        start_reg, start_next;

    logic        accept;
    logic        drain_done;

    assign accept     = bus.req_valid && (state_reg == IDLE) && !bus.flush;
    assign drain_done = unit_mul_reg ? bus.mul_done : bus.div_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_sig_reg   <= 1'b0;
            unit_mul_reg <= 1'b0;
            start_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            op_sig_reg   <= op_sig_next;
            unit_mul_reg <= unit_mul_next;
            start_reg    <= start_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        op_sig_next   = op_sig_reg;
        unit_mul_next = unit_mul_reg;
        start_next    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    unique case (bus.req_op)
                        OP_MULT, OP_MULTU: begin
                            op_a_next     = bus.req_a;
                            op_b_next     = bus.req_b;
                            op_sig_next   = (bus.req_op == OP_MULT);
                            unit_mul_next = 1'b1;
                            start_next    = 1'b1;
                            state_next    = MUL_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero: drop the request, HI/LO untouched.
                            if (bus.req_b != 32'd0) begin
                                op_a_next     = bus.req_a;
                                op_b_next     = bus.req_b;
                                op_sig_next   = (bus.req_op == OP_DIV);
                                unit_mul_next = 1'b0;
                                start_next    = 1'b1;
                                state_next    = DIV_RUN;
                            end
                        end
                        OP_MTHI: hi_next = bus.req_a;
                        OP_MTLO: lo_next = bus.req_a;
                        default: ; // NOP and reserved encoding
                    endcase
                end
            end
            DIV_RUN: begin
                if (bus.flush) begin
                    state_next = DRAIN;
                end else if (!start_reg && bus.div_done) begin
                    state_next = DIV_CAP;
                end
            end
            MUL_RUN: begin
                if (bus.flush) begin
                    state_next = DRAIN;
                end else if (!start_reg && bus.mul_done) begin
                    state_next = MUL_CAP;
                end
            end
            // Flush is deliberately ignored here so the capture completes.
            DIV_CAP: begin
                hi_next    = bus.div_c[63:32];
                lo_next    = bus.div_c[31:0];
                state_next = IDLE;
            end
            MUL_CAP: begin
                hi_next    = bus.mul_c[63:32];
                lo_next    = bus.mul_c[31:0];
                state_next = IDLE;
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;

    assign bus.div_valid = (state_reg == DIV_RUN) && start_reg;
    assign bus.div_sig   = op_sig_reg;
    assign bus.div_a     = op_a_reg;
    assign bus.div_b     = op_b_reg;

    assign bus.mul_valid = (state_reg == MUL_RUN) && start_reg;
    assign bus.mul_sig   = op_sig_reg;
    assign bus.mul_a     = op_a_reg;
    assign bus.mul_b     = op_b_reg;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl.
// Models a divider and a multiplier with programmable latency (done is high
// whenever the unit is idle, result garbled while busy), keeps an
// architectural HI/LO reference, and runs directed then random operations.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // ------------------------------------------------------------------
    // External unit models
    // ------------------------------------------------------------------
    int div_lat = 3;
    int mul_lat = 3;
    int div_pulses = 0;
    int mul_pulses = 0;

    logic        div_busy, mul_busy;
    int          div_cnt, mul_cnt;
    logic [63:0] div_res, mul_res;

    function automatic logic [63:0] unit_div(input logic sig, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sig) begin
            sa = a;
            sb = b;
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] unit_mul(input logic sig, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sig ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sig ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            div_busy <= 1'b0;
            div_cnt  <= 0;
            div_res  <= 64'd0;
        end else if (bus.div_valid) begin
            div_busy <= 1'b1;
            div_cnt  <= div_lat;
            div_res  <= unit_div(bus.div_sig, bus.div_a, bus.div_b);
        end else if (div_busy) begin
            if (div_cnt <= 1) div_busy <= 1'b0;
            else div_cnt <= div_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            mul_busy <= 1'b0;
            mul_cnt  <= 0;
            mul_res  <= 64'd0;
        end else if (bus.mul_valid) begin
            mul_busy <= 1'b1;
            mul_cnt  <= mul_lat;
            mul_res  <= unit_mul(bus.mul_sig, bus.mul_a, bus.mul_b);
        end else if (mul_busy) begin
            if (mul_cnt <= 1) mul_busy <= 1'b0;
            else mul_cnt <= mul_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.div_valid) div_pulses <= div_pulses + 1;
        if (bus.mul_valid) mul_pulses <= mul_pulses + 1;
    end

    assign bus.div_done = !div_busy;
    assign bus.div_c    = div_busy ? ~div_res : div_res;
    assign bus.mul_done = !mul_busy;
    assign bus.mul_c    = mul_busy ? ~mul_res : mul_res;

    // ------------------------------------------------------------------
    // Architectural reference: HI/LO after each completed instruction
    // ------------------------------------------------------------------
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      x, y, q, r;
        logic [63:0] p, tq, tr;
        case (op)
            3'd1: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                p = x * y;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd3, 3'd4: begin
                if (b != 32'd0) begin
                    x = (op == 3'd3) ? longint'($signed(a)) : longint'({32'd0, a});
                    y = (op == 3'd3) ? longint'($signed(b)) : longint'({32'd0, b});
                    q = x / y;
                    r = x - q * y;
                    tq = q;
                    tr = r;
                    exp_lo = tq[31:0];
                    exp_hi = tr[31:0];
                end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: plain run; mode 1: flush 5 cycles after start, with an MTLO
    // waiting through DRAIN; mode 2: flush held during the capture cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic is_div, is_mul, flag;
        int   k, p0_div, p0_mul;
        is_div = (op == 3'd3 || op == 3'd4) && (b != 32'd0);
        is_mul = (op == 3'd1 || op == 3'd2);
        flag   = 1'b0;

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        check("ready_before", bus.req_ready, 1);
        p0_div = div_pulses;
        p0_mul = mul_pulses;

        @(negedge clk);
        bus.req_valid = 1'b0;
        if (mode != 1) model_apply(op, a, b);
        check("busy_start", bus.busy, is_div | is_mul);
        check("div_valid_start", bus.div_valid, is_div);
        check("mul_valid_start", bus.mul_valid, is_mul);
        if (is_div) begin
            check("div_a", bus.div_a, a);
            check("div_b", bus.div_b, b);
            check("div_sig", bus.div_sig, op == 3'd3);
        end
        if (is_mul) begin
            check("mul_a", bus.mul_a, a);
            check("mul_b", bus.mul_b, b);
            check("mul_sig", bus.mul_sig, op == 3'd1);
        end

        k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
            check("ready_vs_busy", bus.req_ready, !bus.busy);
            check("single_valid", {bus.div_valid, bus.mul_valid}, 0);
            if (mode == 1) begin
                if (k == 5) bus.flush = 1'b1;
                if (k == 6) begin
                    bus.flush = 1'b0;
                    check("drain_busy", bus.busy, 1);
                    bus.req_valid = 1'b1;
                    bus.req_op    = 3'd6;
                    bus.req_a     = 32'h1357_2468;
                    bus.req_b     = 32'd0;
                end
                if (bus.busy) begin
                    check("drain_hi_hold", bus.hi, exp_hi);
                    check("drain_lo_hold", bus.lo, exp_lo);
                end
            end
            if (mode == 2) begin
                if (flag) bus.flush = 1'b1;
                if (bus.busy && (is_mul ? bus.mul_done : bus.div_done)) flag = 1'b1;
            end
        end
        bus.flush = 1'b0;

        check("finished", bus.busy, 0);
        check("ready_idle", bus.req_ready, 1);
        check("div_pulses", 64'(div_pulses - p0_div), is_div);
        check("mul_pulses", 64'(mul_pulses - p0_mul), is_mul);
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
        $display("[TB] op=%0d a=%h b=%h mode=%0d -> hi=%h lo=%h", op, a, b, mode, bus.hi, bus.lo);

        if (mode == 1) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            model_apply(3'd6, 32'h1357_2468, 32'd0);
            check("post_drain_mtlo", bus.lo, exp_lo);
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int          r_mode;

        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_valids", {bus.div_valid, bus.mul_valid}, 0);

        div_lat = 4;
        run_op(3'd4, 32'd100, 32'd7, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(3'd4, 32'd55, 32'd0, 0);
        mul_lat = 2;
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);

        // Flush in IDLE blocks the request for that cycle only.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_a     = 32'hCAFE_F00D;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("idle_flush_block", bus.hi, exp_hi);
        $display("[TB] mthi under flush -> hi=%h", bus.hi);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, 0);

        div_lat = 12;
        run_op(3'd3, 32'd1234567, 32'd89, 1);
        div_lat = 3;
        mul_lat = 5;
        run_op(3'd1, 32'h8000_0001, 32'hFFFF_FFFD, 2);
        run_op(3'd4, 32'hF000_0000, 32'd3, 2);

        // Reset during DIV_RUN
        div_lat = 10;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_valid", bus.div_valid, 0);
        $display("[TB] reset during DIV_RUN -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        resetn = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        for (int i = 0; i < 30; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (r_op == 3'd3 && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd1;
            div_lat = $urandom_range(1, 6);
            mul_lat = $urandom_range(1, 6);
            r_mode  = 0;
            if ((r_op == 3'd1 || r_op == 3'd2 || ((r_op == 3'd3 || r_op == 3'd4) && r_b != 32'd0))
                && $urandom_range(0, 3) == 0) r_mode = 2;
            run_op(r_op, r_a, r_b, r_mode);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have these ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have these request ports: req_valid  in  1  request present; req_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP); req_a  in  32  rs operand; req_b  in  32  rt operand; req_ready  out  1  request accepted this cycle.
REQ-003 SHALL have these control and status ports: flush  in  1  squash in-flight op; busy  out  1  high when state != IDLE; hi  out  32  HI register; lo  out  32  LO register.
REQ-004 SHALL have these divider ports: div_valid  out  1  start pulse; div_sig  out  1  signed; div_a  out  32  dividend; div_b  out  32  divisor; div_done  in  1  divider completion; div_c  in  64  {remainder, quotient}.
REQ-005 SHALL have these multiplier ports: mul_valid, mul_sig, mul_a, mul_b, mul_done, mul_c, with the same widths and protocol as the divider ports; mul_c = {high, low}.

Function
REQ-006 SHALL implement states IDLE, DIV_RUN, DIV_CAP, MUL_RUN, MUL_CAP, DRAIN.
REQ-007 SHALL drive req_ready = (state == IDLE); a request is accepted when req_valid && req_ready && !flush.
REQ-008 SHALL, on an accepted MTHI or MTLO, write req_a into hi or lo at that clock edge and remain in IDLE.
REQ-009 SHALL, on an accepted DIV or DIVU with req_b != 0, latch req_a, req_b and sig (1 for DIV) into operand registers and enter DIV_RUN; MULT and MULTU likewise enter MUL_RUN.
REQ-010 SHALL, on an accepted DIV or DIVU with req_b == 0, neither start the divider nor change hi or lo, and remain in IDLE.
REQ-011 SHALL drive div_a, div_b and div_sig from the operand registers, held stable from the DIV_RUN entry edge until DIV_CAP or DRAIN exits; the multiplier operands follow the same rule.
REQ-012 SHALL assert div_valid (or mul_valid) for exactly one cycle, the first cycle of DIV_RUN (or MUL_RUN), and hold it low in every other cycle, including all of DRAIN.
REQ-013 SHALL ignore div_done and mul_done outside the RUN and DRAIN states, because both units report done while idle.
REQ-014 SHALL, in the RUN states after the start cycle, move DIV_RUN to DIV_CAP (or MUL_RUN to MUL_CAP) on the first cycle div_done (or mul_done) is high.
REQ-015 SHALL, in a CAP state, capture hi = c[63:32] and lo = c[31:0] from div_c or mul_c, then return to IDLE; the result is visible on hi and lo in the cycle after CAP.
REQ-016 SHALL, when flush is high in DIV_RUN or MUL_RUN, go to DRAIN at that edge without capturing a result.
REQ-017 SHALL, in DRAIN, wait for the done of the unit in use, then return to IDLE with hi and lo unchanged.
REQ-018 SHALL treat flush in the CAP state as having no effect, so the capture completes.
REQ-019 SHALL treat flush in IDLE as blocking acceptance in that cycle only.
REQ-020 SHALL keep hi and lo unchanged in every state other than CAP, and other than IDLE accepting MTHI or MTLO.
REQ-021 SHALL drive busy = (state != IDLE).

Reset
REQ-022 SHALL, on resetn low at a clock edge, set state = IDLE, hi = 0, lo = 0, all operand registers = 0, and div_valid = mul_valid = 0.
REQ-023 SHALL, if reset occurs mid-operation, discard the in-flight result; the external units are reset by the same resetn.

Verification
REQ-024 SHALL cover DIVU with a = 100, b = 7 -> exactly one div_valid pulse, req_ready low until after DIV_CAP, then hi = 2, lo = 14.
REQ-025 SHALL cover DIV with a = 0xFFFFFFF9 (-7), b = 2 -> div_sig = 1, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-026 SHALL cover DIVU with b = 0 issued after MTHI 0xDEADBEEF -> div_valid never asserted, req_ready stays high, hi = 0xDEADBEEF, lo unchanged.
REQ-027 SHALL cover MULTU with a = 0xFFFFFFFF, b = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE after MUL_CAP.
REQ-028 SHALL cover flush asserted 5 cycles after a DIV start -> state DRAIN, no second div_valid, hi and lo unchanged after div_done, and the next request accepted only once back in IDLE.
REQ-029 SHALL cover resetn low during DIV_RUN -> next cycle state = IDLE, hi = lo = 0, req_ready = 1.
